fetch_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register for the 16-bit RISC pipeline.
- Keeps the PC, drives a synchronous-read instruction memory, and registers the fetched instruction, its PC and PC+1.
- Presents instr_code (opcode field) directly to the decode control unit.
- Handles decode-stage stalls and branch/jr/jal redirects, with squash of in-flight fetches.

---
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register for the 16-bit RISC pipeline, with a one-entry skid for stalls.
// Optional perf counters (perf_fetched, perf_bubbles) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter int unsigned            PC_WIDTH    = 16,
    parameter int unsigned            INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [3:0]             instr_code,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [PC_WIDTH-1:0]    id_pc_plus1
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_bubbles
`endif
);

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_REDIRECT
    } mode_e;

    typedef struct packed {
        logic                   valid;
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
        logic [PC_WIDTH-1:0]    pc_plus1;
    } ifid_t;

    mode_e                  mode;
    logic [PC_WIDTH-1:0]    pc_q;
    logic                   req_valid;
    logic [PC_WIDTH-1:0]    req_pc;
    logic                   hold_valid;
    logic [INSTR_WIDTH-1:0] hold_instr;
    logic [PC_WIDTH-1:0]    hold_pc;
    ifid_t                  ifid_q;
    ifid_t                  ifid_ld;

    always_comb begin
        mode = MODE_RUN;
        if (redirect_valid)
            mode = MODE_REDIRECT;
        else if (stall)
            mode = MODE_STALL;
    end

    assign imem_addr = pc_q;
    assign imem_en   = !rst && !stall && !redirect_valid;

    // Skid entry outranks the in-flight read: it is the older instruction.
    always_comb begin
        ifid_ld       = '0;
        ifid_ld.instr = NOP_INSTR;
        if (hold_valid) begin
            ifid_ld.valid = 1'b1;
            ifid_ld.instr = hold_instr;
            ifid_ld.pc    = hold_pc;
        end else if (req_valid) begin
            ifid_ld.valid = 1'b1;
            ifid_ld.instr = imem_rdata;
            ifid_ld.pc    = req_pc;
        end
        ifid_ld.pc_plus1 = ifid_ld.pc + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            req_valid <= 1'b0;
            req_pc    <= '0;
        end else begin
            case (mode)
                MODE_REDIRECT: begin
                    pc_q      <= redirect_pc;
                    req_valid <= 1'b0;
                end
                MODE_STALL: req_valid <= 1'b0;
                default: begin
                    pc_q      <= pc_q + 1'b1;
                    req_valid <= 1'b1;
                    req_pc    <= pc_q;
                end
            endcase
        end
    end

    // A multi-cycle stall issues no reads, so the skid entry captured on the first stall edge persists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
        end else begin
            case (mode)
                MODE_STALL: begin
                    if (req_valid) begin
                        hold_valid <= 1'b1;
                        hold_instr <= imem_rdata;
                        hold_pc    <= req_pc;
                    end
                end
                default: hold_valid <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q       <= '0;
            ifid_q.instr <= NOP_INSTR;
        end else begin
            case (mode)
                MODE_REDIRECT: begin
                    ifid_q.valid <= 1'b0;
                    ifid_q.instr <= NOP_INSTR;
                end
                MODE_STALL: ifid_q <= ifid_q;
                default:    ifid_q <= ifid_ld;
            endcase
        end
    end

    assign id_valid    = ifid_q.valid;
    assign id_instr    = ifid_q.instr;
    assign instr_code  = ifid_q.instr[INSTR_WIDTH-1 -: 4];
    assign id_pc       = ifid_q.pc;
    assign id_pc_plus1 = ifid_q.pc_plus1;

`ifdef FETCH_PERF_CNT_EN
    logic run_fetch;
    logic run_bubble;

    assign run_fetch  = (mode == MODE_RUN) && ifid_ld.valid;
    assign run_bubble = ((mode == MODE_RUN) && !ifid_ld.valid) || (mode == MODE_REDIRECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (run_fetch && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (run_bubble && perf_bubbles != 32'hFFFF_FFFF)
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected fetch PCs and direct checks;
// a monitor pops and compares on each falling edge. imem[n] = 16'h1000 + n.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [3:0]  instr_code;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .instr_code     (instr_code),
        .id_pc          (id_pc),
        .id_pc_plus1    (id_pc_plus1)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_en) imem_rdata <= 16'h1000 + imem_addr;

    assert property (@(posedge clk) disable iff (rst)
        (!stall && !redirect_valid) |-> !(dut.hold_valid && dut.req_valid))
        else $error("FAIL skid_invariant: hold_valid and req_valid both 1 at run edge, required not both");

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    logic [15:0] sb[$];
    dchk_t       dq[$];
    int          n_pass = 0;
    int          n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: owns all comparisons and both counters.
    initial begin : monitor
        logic        s_st, s_rd, s_rst, have_last;
        logic [15:0] e_pc, e_ins, last_pc, last_ins;
        dchk_t       d;
        have_last = 1'b0;
        last_pc   = '0;
        last_ins  = '0;
        forever begin
            @(posedge clk);
            s_st  = stall;
            s_rd  = redirect_valid;
            s_rst = rst;
            @(negedge clk);
            while (dq.size() > 0) begin
                d = dq.pop_front();
                chk(d.name, d.act, d.exp);
            end
            if (!s_rst && !rst && !s_rd) begin
                if (s_st) begin
                    if (have_last) begin
                        chk("stall_hold_pc", 32'(id_pc), 32'(last_pc));
                        chk("stall_hold_instr", 32'(id_instr), 32'(last_ins));
                    end
                end else if (id_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 32'(id_valid), 32'd0);
                    end else begin
                        e_pc  = sb.pop_front();
                        e_ins = 16'h1000 + e_pc;
                        chk("id_pc", 32'(id_pc), 32'(e_pc));
                        chk("id_instr", 32'(id_instr), 32'(e_ins));
                        chk("instr_code", 32'(instr_code), 32'(e_ins[15:12]));
                        chk("id_pc_plus1", 32'(id_pc_plus1), 32'(16'(e_pc + 16'd1)));
                        last_pc   = e_pc;
                        last_ins  = e_ins;
                        have_last = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic dpush(input string name, input logic [31:0] act, input logic [31:0] exp);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dq.push_back(d);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic push_range(input logic [15:0] first, input int cnt);
        for (int i = 0; i < cnt; i++) sb.push_back(16'(first + 16'(i)));
    endtask

    task automatic do_redirect(input logic [15:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick(1);
        redirect_valid = 1'b0;
        stall          = 1'b0;
    endtask

    initial begin : stim
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        dpush("rst_id_valid", 32'(id_valid), 32'd0);
        dpush("rst_id_instr", 32'(id_instr), 32'h0000);
        dpush("rst_instr_code", 32'(instr_code), 32'h0);
        dpush("rst_id_pc", 32'(id_pc), 32'h0);
        dpush("rst_id_pc_plus1", 32'(id_pc_plus1), 32'h0);
        dpush("rst_imem_en", 32'(imem_en), 32'd0);
        dpush("rst_imem_addr", 32'(imem_addr), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line fetch, then a 3-cycle stall with instruction 5 in flight.
        push_range(16'h0000, 9);
        tick(6);
        stall = 1'b1;
        #1 dpush("stall_imem_en", 32'(imem_en), 32'd0);
        tick(3);
        stall = 1'b0;
        tick(4);

        // Redirect while id_pc=8: 9 and 10 must never show.
        dpush("pre_redirect_pc", 32'(id_pc), 32'h0008);
        do_redirect(16'h0040);
        dpush("redir_id_valid", 32'(id_valid), 32'd0);
        dpush("redir_instr_code", 32'(instr_code), 32'h0);
        dpush("redir_id_instr", 32'(id_instr), 32'h0000);
        dpush("redir_imem_addr", 32'(imem_addr), 32'h0040);
        push_range(16'h0040, 2);
        tick(3);

        // Stall fills the skid with 0x42, then stall+redirect discards it.
        stall = 1'b1;
        tick(1);
        dpush("stall2_imem_en", 32'(imem_en), 32'd0);
        do_redirect(16'h0080);
        dpush("redir_stall_id_valid", 32'(id_valid), 32'd0);
        push_range(16'h0080, 2);
        tick(3);

        // PC wrap through 0xFFFF.
        do_redirect(16'hFFFE);
        push_range(16'hFFFE, 4);
        tick(5);
        dpush("wrap_imem_addr", 32'(imem_addr), 32'h0003);

        // Asynchronous reset mid-stream, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        dpush("arst_id_valid", 32'(id_valid), 32'd0);
        dpush("arst_id_pc", 32'(id_pc), 32'h0);
        dpush("arst_id_pc_plus1", 32'(id_pc_plus1), 32'h0);
        dpush("arst_id_instr", 32'(id_instr), 32'h0000);
        dpush("arst_imem_en", 32'(imem_en), 32'd0);
        dpush("arst_imem_addr", 32'(imem_addr), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        dpush("arst_perf_fetched", perf_fetched, 32'd0);
        dpush("arst_perf_bubbles", perf_bubbles, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // 1 bubble + 10 fetches, then a redirect bubble.
        push_range(16'h0000, 10);
        tick(11);
        do_redirect(16'h0010);
        dpush("final_id_valid", 32'(id_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        dpush("perf_fetched", perf_fetched, 32'd10);
        dpush("perf_bubbles", perf_bubbles, 32'd2);
`endif
        dpush("sb_empty", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 10 && dq.size() != 0; i++) @(negedge clk);
        if (dq.size() != 0)
            $display("FAIL drain_timeout: %0d checks pending, expected 0", dq.size());
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
